// File: rtl/button_pkg.sv
// Shared types and width helpers for the button conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package button_pkg;

    // Per-channel press tracking state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } ch_state_e;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Counter widths for the default build (100 MHz, 1 ms tick).
    localparam int DEF_DB_CNT_W   = $clog2(10000);
    localparam int DEF_TICK_CNT_W = $clog2(100000);
    localparam int DEF_HOLD_CNT_W = $clog2(500);
    localparam int DEF_RPT_CNT_W  = $clog2(100);

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus: raw pins and repeat enables in, conditioned event vectors out.
// Latency: n/a (wiring only).
// Backpressure: none; every output is a level or single-cycle pulse.
// Ports: master drives btn_in/repeat_en and observes the outputs;
//        slave (the conditioner) does the reverse.
interface button_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_in;     // raw asynchronous pins
    logic [N_BTN-1:0] repeat_en;  // per-channel auto-repeat enable
    logic [N_BTN-1:0] level;      // debounced pressed state
    logic [N_BTN-1:0] press;      // one-cycle pulse on debounced press
    logic [N_BTN-1:0] rel_pulse;  // one-cycle pulse on debounced release
    logic [N_BTN-1:0] held;       // long press in progress
    logic [N_BTN-1:0] action;     // press or auto-repeat pulse

    modport master (
        output btn_in, repeat_en,
        input  level, press, rel_pulse, held, action
    );

    modport slave (
        input  btn_in, repeat_en,
        output level, press, rel_pulse, held, action
    );
endinterface

// File: rtl/button_channel.sv
// One button: 2-flop sync, optional inversion, debounce, edge pulses, hold/repeat FSM.
// Latency: pin edge to level/press is 2 + DB_CYCLES cycles; all outputs registered.
// Backpressure: none; pulses are single-cycle and never stall.
// Ports: clk, rst_n; btn_i raw pin; repeat_en_i; tick_i shared ms tick;
//        level_o, press_o, rel_o, held_o, action_o.
module button_channel
    import button_pkg::*;
#(
    parameter int   DB_CYCLES    = 10000,
    parameter logic INVERT       = 1'b0,
    parameter int   HOLD_TICKS   = 500,
    parameter int   REPEAT_TICKS = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    input  logic repeat_en_i,
    input  logic tick_i,
    output logic level_o,
    output logic press_o,
    output logic rel_o,
    output logic held_o,
    output logic action_o
);
    localparam int DW = cnt_w(DB_CYCLES);
    localparam int HW = cnt_w(HOLD_TICKS);
    localparam int RW = cnt_w(REPEAT_TICKS);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_TICKS - 1);

    logic          sync1_q, sync2_q;
    logic          raw;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          level_q, level_d;
    logic          press_q, rel_q, held_q, action_q;
    logic          rise, fall;
    ch_state_e     state_q;
    logic [HW-1:0] hold_cnt_q;
    logic [RW-1:0] rpt_cnt_q;

    assign raw = sync2_q ^ INVERT;

    // Count consecutive samples disagreeing with the accepted level; any
    // agreeing sample restarts the count, and acceptance clears it.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (raw != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = raw;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign rise = ~level_q &  level_d;
    assign fall =  level_q & ~level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            press_q  <= rise;
            rel_q    <= fall;
        end
    end

    // Hold/repeat FSM. A release always wins over a coincident tick, so no
    // held or repeat pulse can appear on the release edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rpt_cnt_q  <= '0;
            held_q     <= 1'b0;
            action_q   <= 1'b0;
        end else begin
            action_q <= 1'b0;
            if (fall) begin
                state_q <= ST_IDLE;
                held_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            state_q    <= ST_PRESSED;
                            hold_cnt_q <= '0;
                            action_q   <= 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (tick_i) begin
                            if (hold_cnt_q == HOLD_LAST) begin
                                state_q   <= ST_HELD;
                                held_q    <= 1'b1;
                                action_q  <= repeat_en_i;
                                rpt_cnt_q <= '0;
                            end else begin
                                hold_cnt_q <= hold_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_HELD: begin
                        // The period keeps running with repeat disabled so
                        // re-enabling stays on the original cadence.
                        if (tick_i) begin
                            if (rpt_cnt_q == RPT_LAST) begin
                                action_q  <= repeat_en_i;
                                rpt_cnt_q <= '0;
                            end else begin
                                rpt_cnt_q <= rpt_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign level_o  = level_q;
    assign press_o  = press_q;
    assign rel_o    = rel_q;
    assign held_o   = held_q;
    assign action_o = action_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: shared ms prescaler plus N_BTN channels.
// Latency: pin edge to level/press is 2 + DB_CYCLES cycles; outputs registered.
// Backpressure: none; event outputs are single-cycle pulses.
// Ports: clk, rst_n (async, active-low); bus (slave) carries btn_in/repeat_en
//        in and level/press/rel_pulse/held/action out.
module button_conditioner
    import button_pkg::*;
#(
    parameter int               N_BTN        = 5,
    parameter int               DB_CYCLES    = 10000,
    parameter logic [N_BTN-1:0] INVERT       = '0,
    parameter int               TICK_CYCLES  = 100000,
    parameter int               HOLD_TICKS   = 500,
    parameter int               REPEAT_TICKS = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    button_conditioner_if.slave bus
);
    localparam int TW = cnt_w(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic [TW-1:0]    pre_q;
    logic             tick;
    logic [N_BTN-1:0] level_w, press_w, rel_w, held_w, action_w;

    // Free-running; hold latency therefore depends on tick phase at press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (pre_q == TICK_LAST) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    assign tick = (pre_q == TICK_LAST);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .INVERT       (INVERT[i]),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_i       (bus.btn_in[i]),
            .repeat_en_i (bus.repeat_en[i]),
            .tick_i      (tick),
            .level_o     (level_w[i]),
            .press_o     (press_w[i]),
            .rel_o       (rel_w[i]),
            .held_o      (held_w[i]),
            .action_o    (action_w[i])
        );
    end

    assign bus.level     = level_w;
    assign bus.press     = press_w;
    assign bus.rel_pulse = rel_w;
    assign bus.held      = held_w;
    assign bus.action    = action_w;

endmodule
